mips_multicycle_cpu: RTL

Multi-cycle MIPS32-subset core and the next generation of the team's single-cycle CPU top. A control FSM sequences each instruction over several cycles. One unified memory port serves both instructions and data, and it uses a request/ready handshake so wait-state memories can be attached. It sits at the top of the CPU hierarchy, owns the register file, PC and ALU, and adds halt-on-illegal and a retired-instruction counter.

---
 rtl/mips_multicycle_cpu.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS32-subset core with a unified request/ready memory port.
// Each instruction walks a control FSM; PC, IR, MDR, A, B, ALUOut and the register file live here.
module mips_multicycle_cpu #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        halted,
   output logic [31:0] pc,
   output logic [31:0] retired
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC,
      S_ALUWB,
      S_ADDIEX,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] rf_q [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;
   logic [31:0] alu_res;
   logic        funct_ok;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

   // Bus outputs are pure decodes of state; reset drops a pending request immediately.
   assign mem_req   = !reset && (state_q == S_FETCH || state_q == S_MEMREAD ||
                                 state_q == S_MEMWRITE);
   assign mem_we    = mem_req && (state_q == S_MEMWRITE);
   assign mem_addr  = (state_q == S_FETCH) ? {pc_q[31:2], 2'b00} : {aluout_q[31:2], 2'b00};
   assign mem_wdata = b_q;
   assign halted    = (state_q == S_HALT);
   assign pc        = pc_q;
   assign retired   = retired_q;

   always_comb begin
      alu_res  = '0;
      funct_ok = 1'b1;
      case (funct)
         FN_ADD:  alu_res = a_q + b_q;
         FN_SUB:  alu_res = a_q - b_q;
         FN_AND:  alu_res = a_q & b_q;
         FN_OR:   alu_res = a_q | b_q;
         FN_SLT:  alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
         default: funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      rf_we    = 1'b0;
      rf_waddr = rd;
      rf_wdata = aluout_q;
      retire   = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d      = (rs == 5'd0) ? 32'd0 : rf_q[rs];
            b_d      = (rt == 5'd0) ? 32'd0 : rf_q[rt];
            aluout_d = pc_q + {imm_sext[29:0], 2'b00};
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  if (HALT_ON_ILLEGAL) begin
                     state_d = S_HALT;
                  end else begin
                     state_d = S_FETCH;
                     retire  = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR: begin
            aluout_d = a_q + imm_sext;
            state_d  = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_ready) begin
               mdr_d   = mem_rdata;
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (funct_ok) begin
               aluout_d = alu_res;
               state_d  = S_ALUWB;
            end else if (HALT_ON_ILLEGAL) begin
               state_d = S_HALT;
            end else begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ALUWB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEX: begin
            aluout_d = a_q + imm_sext;
            state_d  = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            if (a_q == b_q) pc_d = aluout_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      retired_d = retired_q + {31'b0, retire};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         mdr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         aluout_q  <= '0;
         retired_q <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mdr_q     <= mdr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         aluout_q  <= aluout_d;
         retired_q <= retired_d;
         // Register 0 is hardwired; its writes are dropped here.
         if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
      end
   end

endmodule
